rat_reduce: RTL
===============

# rat_reduce

Normalises an unsigned rational num/den to lowest terms. It computes the GCD with a binary (Stein) GCD and then divides both operands by it using iterative restoring division. It sits directly downstream of the rational multiplier in the rational datapath, and consumes its s_num/s_den products before they are reused or stored. A valid/ready handshake on both sides lets it absorb the multi-cycle latency.

## Interface
- WIDTH, 32, operand width in bits; unsigned magnitude.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_num/in_den valid.
- in_ready  out  1  block can accept; combinational, equals state==IDLE.
- in_num  in  WIDTH  numerator.
- in_den  in  WIDTH  denominator.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_num  out  WIDTH  reduced numerator.
- out_den  out  WIDTH  reduced denominator.
- out_div0  out  1  input denominator was zero.

## Operation
- States:
  - IDLE: waits for input.
  - GCD: one Stein step per cycle.
  - DIV: two parallel dividers.
  - DONE: presents the result.
- Accept in IDLE when in_valid && in_ready. Capture num/den into n_q/d_q and a=num, b=den, k=0.
- Special cases, decided at accept, go straight to DONE:
  - den==0: out_num=num, out_den=0, out_div0=1.
  - num==0 (den≠0): out 0/1.
- GCD state. Each cycle, evaluated in order:
  - a==b: g = a<<k, go to DIV.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - else: larger -= smaller.
  - Bound: G ≤ 2*WIDTH cycles.
- DIV state: two rat_divu instances compute n_q/g and d_q/g in exactly WIDTH cycles. Remainders are zero by construction and are not checked. Quotients load out_num/out_den, then go to DONE.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle.
  - No new input is accepted in the handshake cycle.
- Reset (any state, mid-operation included) aborts immediately:
  - state=IDLE.
  - out_valid=0, out_num=0, out_den=0, out_div0=0, k=0.
  - in_ready=1 as soon as rst_n is low.

## Timing
- Accept edge = t0.
- Special case: out_valid high from t0+1.
- General case:
  - GCD occupies cycles t0+1 … t0+G. The cycle that detects a==b counts in G.
  - DIV occupies WIDTH cycles.
  - out_valid high from t0+G+WIDTH+1.
- Minimum spacing between accepts is latency+1 (IDLE cycle after DONE).
- in_* need only be stable in the accept cycle.

## Configuration
- RAT_REDUCE_FASTPATH_EN.
- Defined: if g==1 at GCD exit, DIV is skipped. out_num/out_den load n_q/d_q directly and out_valid is high from t0+G+1.
- Undefined: DIV always runs WIDTH cycles. Results are identical; only latency differs.

## Structure
- Package rat_pkg holds:
  - the state enum (IDLE, GCD, DIV, DONE);
  - default RAT_WIDTH=32, shared with the multiplier;
  - the K_W=$clog2(WIDTH+1) constant for the k counter.
- One sub-module, rat_divu: WIDTH-cycle unsigned restoring divider.
  - Ports: start, dividend, divisor, quotient, done.
  - Instantiated twice.

## Test plan
- 12/18 (WIDTH=32) → 2/3, out_div0=0. G=5, out_valid at t0+38; out_valid at t0+6 with fastpath must not occur (g=6).
- 7/5 → 7/5. With RAT_REDUCE_FASTPATH_EN, out_valid at t0+G+1. Without it, at t0+G+33.
- 0/7 → 0/1 and 5/0 → 5/0 with out_div0=1. Both have out_valid at t0+1.
- 0xFFFFFFFF/0xFFFFFFFF → 1/1. 0x80000000/0x40000000 → 2/1.
- out_ready held low 10 cycles in DONE → outputs stable, in_ready=0, in_valid ignored. Release → handshake, then IDLE.
- rst_n pulsed low mid-GCD and mid-DIV → all outputs 0, in_ready=1. Next input 4/6 → 2/3 with correct latency.

Source files
------------

// File: rtl/rat_reduce_pkg.sv
// Shared types and constants for the rational datapath (rat_reduce and the multiplier).
// Holds the reducer state encoding and the k-counter width helper.
package rat_pkg;

  localparam int RAT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GCD  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } rat_state_e;

  // Width of a counter that must reach w (k counts common factors of two).
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int K_W = k_width(RAT_WIDTH);

endpackage

// File: rtl/rat_reduce_if.sv
// Valid/ready request and response bundle for rat_reduce.
// master drives operands and accepts results; slave is the reducer itself.
interface rat_reduce_if
  import rat_pkg::*;
#(
  parameter int WIDTH = RAT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_den;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic [WIDTH-1:0] out_den;
  logic             out_div0;

  modport master (
    output in_valid, in_num, in_den, out_ready,
    input  in_ready, out_valid, out_num, out_den, out_div0
  );

  modport slave (
    input  in_valid, in_num, in_den, out_ready,
    output in_ready, out_valid, out_num, out_den, out_div0
  );

endinterface

// File: rtl/rat_reduce_divu.sv
// rat_divu: unsigned restoring divider, one quotient bit per cycle, WIDTH cycles per divide.
// done is high in the cycle whose edge completes the last step; quotient is valid in that cycle.
module rat_divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_s;

  // Shift one dividend bit into the partial remainder; subtract if it fits.
  function automatic logic [2*WIDTH-1:0] divu_step(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] quo,
                                                   input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (sh >= {1'b0, dvs}) begin
      return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end else begin
      return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Next remainder/quotient pair from the current iteration state.
  always_comb begin
    {rem_s, quo_s} = divu_step(rem_r, quo_r, dvs_r);
  end

  assign quotient = quo_s;
  assign done     = busy_r && (cnt_r == CW'(1));

  // Iteration registers: load on start, then step until the count runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      dvs_r  <= divisor;
      cnt_r  <= CW'(WIDTH);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= rem_s;
      quo_r  <= quo_s;
      cnt_r  <= cnt_r - CW'(1);
      busy_r <= (cnt_r != CW'(1));
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/rat_reduce.sv
// rat_reduce: reduces num/den to lowest terms via Stein GCD followed by two restoring dividers.
// Optional macro RAT_REDUCE_FASTPATH_EN skips the divide phase when the GCD is 1.
module rat_reduce
  import rat_pkg::*;
#(
  parameter int WIDTH = RAT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  rat_reduce_if.slave bus
);

  localparam int KW = k_width(WIDTH);

  rat_state_e       state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [KW-1:0]    k_r, k_s;
  logic [WIDTH-1:0] n_q_r, n_q_s;
  logic [WIDTH-1:0] d_q_r, d_q_s;
  logic [WIDTH-1:0] out_num_r, out_num_s;
  logic [WIDTH-1:0] out_den_r, out_den_s;
  logic             out_div0_r, out_div0_s;
  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] g_s;
  logic             div_start_s;
  logic [WIDTH-1:0] num_quo_s, den_quo_s;
  logic             num_done_s, den_done_s;

  rat_divu #(.WIDTH(WIDTH)) u_div_num (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (n_q_r),
    .divisor  (g_s),
    .quotient (num_quo_s),
    .done     (num_done_s)
  );

  rat_divu #(.WIDTH(WIDTH)) u_div_den (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_s),
    .dividend (d_q_r),
    .divisor  (g_s),
    .quotient (den_quo_s),
    .done     (den_done_s)
  );

  // Next-state and datapath update for the accept / GCD / divide / present sequence.
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    k_s         = k_r;
    n_q_s       = n_q_r;
    d_q_s       = d_q_r;
    out_num_s   = out_num_r;
    out_den_s   = out_den_r;
    out_div0_s  = out_div0_r;
    out_valid_s = out_valid_r;
    div_start_s = 1'b0;
    g_s         = a_r << k_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          n_q_s = bus.in_num;
          d_q_s = bus.in_den;
          a_s   = bus.in_num;
          b_s   = bus.in_den;
          k_s   = '0;
          if (bus.in_den == '0) begin
            out_num_s   = bus.in_num;
            out_den_s   = '0;
            out_div0_s  = 1'b1;
            out_valid_s = 1'b1;
            state_s     = DONE;
          end else if (bus.in_num == '0) begin
            out_num_s   = '0;
            out_den_s   = WIDTH'(1);
            out_div0_s  = 1'b0;
            out_valid_s = 1'b1;
            state_s     = DONE;
          end else begin
            out_div0_s = 1'b0;
            state_s    = GCD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GCD: begin
        if (a_r == b_r) begin
`ifdef RAT_REDUCE_FASTPATH_EN
          if (g_s == WIDTH'(1)) begin
            out_num_s   = n_q_r;
            out_den_s   = d_q_r;
            out_valid_s = 1'b1;
            state_s     = DONE;
          end else begin
            div_start_s = 1'b1;
            state_s     = DIV;
          end
`else
          div_start_s = 1'b1;
          state_s     = DIV;
`endif
        end else if (!a_r[0] && !b_r[0]) begin
          a_s = a_r >> 1;
          b_s = b_r >> 1;
          k_s = k_r + KW'(1);
        end else if (!a_r[0]) begin
          a_s = a_r >> 1;
        end else if (!b_r[0]) begin
          b_s = b_r >> 1;
        end else if (a_r > b_r) begin
          a_s = a_r - b_r;
        end else begin
          b_s = b_r - a_r;
        end
      end
      DIV: begin
        // Both dividers start together and finish on the same edge.
        if (num_done_s && den_done_s) begin
          out_num_s   = num_quo_s;
          out_den_s   = den_quo_s;
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          state_s = DIV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      k_r         <= '0;
      n_q_r       <= '0;
      d_q_r       <= '0;
      out_num_r   <= '0;
      out_den_r   <= '0;
      out_div0_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      k_r         <= k_s;
      n_q_r       <= n_q_s;
      d_q_r       <= d_q_s;
      out_num_r   <= out_num_s;
      out_den_r   <= out_den_s;
      out_div0_r  <= out_div0_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_num   = out_num_r;
  assign bus.out_den   = out_den_r;
  assign bus.out_div0  = out_div0_r;

endmodule
